// File: rtl/sram_arb_2p.sv
// rtl/sram_arb_2p.sv - two-port round-robin arbiter/sequencer for a 1-cycle-latency single-port SRAM.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins conflicts (no rr_ptr).
module sram_arb_2p #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic       gnt0;
  logic       gnt1;
  logic [1:0] rd_pend_q;
  logic [1:0] rd_pend_d;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic rr_ptr_q;
  logic rr_ptr_d;
`endif

  // Grants are masked by rst_n so the SRAM sees no access while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    if (gnt0) begin
      mem_we   = req0_we;
      mem_addr = req0_addr;
      mem_din  = req0_wdata;
    end else if (gnt1) begin
      mem_we   = req1_we;
      mem_addr = req1_addr;
      mem_din  = req1_wdata;
    end
  end

  always_comb begin
    rd_pend_d = {gnt1 & ~req1_we, gnt0 & ~req0_we};
  end

`ifndef SRAM_ARB_FIXED_PRIO_EN
  // The port just served loses the next conflict.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    rsp0_valid = rd_pend_q[0];
    rsp1_valid = rd_pend_q[1];
    rsp0_rdata = rd_pend_q[0] ? mem_dout : '0;
    rsp1_rdata = rd_pend_q[1] ? mem_dout : '0;
  end

endmodule

// File: tb/tb_sram_arb_2p.sv
// tb/tb_sram_arb_2p.sv - scoreboard bench for sram_arb_2p with a behavioural SRAM and arbitration model.
module tb_sram_arb_2p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0]  req0_addr = '0, req1_addr = '0;
  logic [63:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we;
  logic [63:0] rsp0_rdata, rsp1_rdata, mem_din, mem_dout;
  logic [5:0]  mem_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] ref_mem[64];
  logic [63:0] sram[64];
  int          last_win = 1;

  sram_arb_2p #(.DATA_W(64), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // SRAM: write at the edge while we=1, read data registered on dout.
  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor and arbitration model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    int          g;
    logic [63:0] ew_a, ew_d;
    logic        ew_we;
    if (!rst_n) begin
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(req1_ready), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_din", mem_din, 64'd0);
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("rst_rsp_rdata", rsp0_rdata | rsp1_rdata, 64'd0);
      q0.delete();
      q1.delete();
      last_win = 1;
    end else begin
      if (rsp0_valid) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else begin
          e = q0.pop_front();
          chk("rsp0_rdata", rsp0_rdata, e.data);
          chk("rsp0_latency", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("rsp0_rdata_idle", rsp0_rdata, 64'd0);
        if (q0.size() > 0 && q0[0].due <= cyc) begin
          chk("rsp0_missing", 64'(rsp0_valid), 64'd1);
          void'(q0.pop_front());
        end
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else begin
          e = q1.pop_front();
          chk("rsp1_rdata", rsp1_rdata, e.data);
          chk("rsp1_latency", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("rsp1_rdata_idle", rsp1_rdata, 64'd0);
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          chk("rsp1_missing", 64'(rsp1_valid), 64'd1);
          void'(q1.pop_front());
        end
      end

      // Winner: sole requester, else the port that did not win most recently.
      g = -1;
      if (req0_valid && req1_valid) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (last_win == 0) ? 1 : 0;
`endif
      end else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;

      chk("req0_ready", 64'(req0_ready), 64'(g == 0));
      chk("req1_ready", 64'(req1_ready), 64'(g == 1));
      ew_we = 1'b0; ew_a = '0; ew_d = '0;
      if (g == 0) begin ew_we = req0_we; ew_a = 64'(req0_addr); ew_d = req0_wdata; end
      if (g == 1) begin ew_we = req1_we; ew_a = 64'(req1_addr); ew_d = req1_wdata; end
      chk("mem_we", 64'(mem_we), 64'(ew_we));
      chk("mem_addr", 64'(mem_addr), ew_a);
      chk("mem_din", mem_din, ew_d);

      if (g >= 0) begin
        if (ew_we) ref_mem[ew_a[5:0]] = ew_d;
        else begin
          e.data = ref_mem[ew_a[5:0]];
          e.due  = cyc + 1;
          if (g == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        last_win = g;
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic w, input logic [5:0] a,
                          input logic [63:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Hold current commands until each is accepted, then drop its valid.
  task automatic step_hold(input int budget);
    logic a0, a1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      if (!req0_valid && !req1_valid) return;
    end
    checks++;
    failures++;
    $display("FAIL hold_timeout actual=not_accepted required=accepted cycle=%0d", cyc);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic new_cmd(input int p);
    logic [5:0] a;
    a = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
    set_port(p, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
  endtask

  initial begin
    logic a0, a1;
    set_port(0, 1'b1, 1'b1, 6'd9, 64'hDEAD_BEEF_0000_0001);
    repeat (3) @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, 6'd0, 64'd0);
    rst_n = 1'b1;

    set_port(0, 1'b1, 1'b1, 6'd1, 64'hA5A5_A5A5_A5A5_A5A5); step_hold(4);
    set_port(0, 1'b1, 1'b0, 6'd1, 64'd0); step_hold(4);
    set_port(0, 1'b1, 1'b1, 6'd2, 64'h5A5A_5A5A_5A5A_5A5A); step_hold(4);
    set_port(1, 1'b1, 1'b1, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF); step_hold(4);
    repeat (2) begin
      set_port(0, 1'b1, 1'b0, 6'd2, 64'd0);
      set_port(1, 1'b1, 1'b0, 6'd3, 64'd0);
      step_hold(4);
    end
    set_port(1, 1'b1, 1'b1, 6'd63, 64'h0123_4567_89AB_CDEF); step_hold(4);
    set_port(0, 1'b1, 1'b0, 6'd63, 64'd0); step_hold(4);

    // Reset lands while a port 1 read response is pending.
    set_port(1, 1'b1, 1'b0, 6'd5, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    set_port(1, 1'b0, 1'b0, 6'd0, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b0, 6'd1, 64'd0);
    set_port(1, 1'b1, 1'b0, 6'd63, 64'd0);
    step_hold(4);

    // Idle window, then a conflict that must follow the pre-idle pointer.
    set_port(0, 1'b1, 1'b0, 6'd2, 64'd0); step_hold(4);
    repeat (10) @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b0, 6'd3, 64'd0);
    set_port(1, 1'b1, 1'b0, 6'd2, 64'd0);
    step_hold(4);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (a0 || !req0_valid) new_cmd(0);
      if (a1 || !req1_valid) new_cmd(1);
    end

    set_port(0, 1'b0, 1'b0, 6'd0, 64'd0);
    set_port(1, 1'b0, 1'b0, 6'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
